// File: rtl/id_pkg.sv
// id_pkg: shared definitions for the instruction-decode stage.
//   - instruction field positions (opcode, src1, src2, rd, imm)
//   - id_ctrl_t : full decoded control word produced in ID
//   - exe_ctrl_t: subset of the control word carried into EXE
//   - dest_sel  : destination register select helper
package id_pkg;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS1_HI = 25;
  localparam int RS1_LO = 21;
  localparam int RS2_HI = 20;
  localparam int RS2_LO = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int IMM_W  = 16;

  typedef struct packed {
    logic [3:0] exe_cmd;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       wb_en;
    logic       is_imm;
    logic [1:0] br_type;
    logic       single_src;
  } id_ctrl_t;

  // is_imm is consumed inside ID (operand/dest select), so it is not carried.
  typedef struct packed {
    logic [3:0] exe_cmd;
    logic [1:0] br_type;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       wb_en;
    logic       single_src;
  } exe_ctrl_t;

  // Immediate-form instructions write the register named in the src2 slot.
  function automatic logic [4:0] dest_sel(input logic       is_imm,
                                          input logic [4:0] rt,
                                          input logic [4:0] rd);
    return is_imm ? rt : rd;
  endfunction

endpackage

// File: rtl/control_unit.sv
// Control_unit: opcode decoder shared with the rest of the core.
// Ports:
//   opcode      in  6  instruction opcode
//   exec_cmd    out 4  ALU command
//   mem_r_en    out 1  load
//   mem_w_en    out 1  store
//   wb_en       out 1  result written back
//   is_imm      out 1  second operand is the sign-extended immediate
//   branch_type out 2  00 none, 01 BEZ, 10 BNE, 11 JMP
//   single_src  out 1  instruction reads only src1
module Control_unit (
  input  logic [5:0] opcode,
  output logic [3:0] exec_cmd,
  output logic       mem_r_en,
  output logic       mem_w_en,
  output logic       wb_en,
  output logic       is_imm,
  output logic [1:0] branch_type,
  output logic       single_src
);

  always_comb begin
    exec_cmd    = 4'b0000;
    mem_r_en    = 1'b0;
    mem_w_en    = 1'b0;
    wb_en       = 1'b0;
    is_imm      = 1'b0;
    branch_type = 2'b00;
    single_src  = 1'b0;
    case (opcode)
      6'd1:  begin exec_cmd = 4'b0000; wb_en = 1'b1; end  // ADD
      6'd3:  begin exec_cmd = 4'b0010; wb_en = 1'b1; end  // SUB
      6'd5:  begin exec_cmd = 4'b0100; wb_en = 1'b1; end  // AND
      6'd6:  begin exec_cmd = 4'b0101; wb_en = 1'b1; end  // OR
      6'd7:  begin exec_cmd = 4'b0110; wb_en = 1'b1; end  // NOR
      6'd8:  begin exec_cmd = 4'b0111; wb_en = 1'b1; end  // XOR
      6'd9:  begin exec_cmd = 4'b1000; wb_en = 1'b1; end  // SLA
      6'd10: begin exec_cmd = 4'b1000; wb_en = 1'b1; end  // SLL
      6'd11: begin exec_cmd = 4'b1001; wb_en = 1'b1; end  // SRA
      6'd12: begin exec_cmd = 4'b1010; wb_en = 1'b1; end  // SRL
      6'd32: begin                                         // ADDI
        exec_cmd = 4'b0000; wb_en = 1'b1; is_imm = 1'b1; single_src = 1'b1;
      end
      6'd33: begin                                         // SUBI
        exec_cmd = 4'b0010; wb_en = 1'b1; is_imm = 1'b1; single_src = 1'b1;
      end
      6'd36: begin                                         // LD
        mem_r_en = 1'b1; wb_en = 1'b1; is_imm = 1'b1; single_src = 1'b1;
      end
      6'd37: begin                                         // ST
        mem_w_en = 1'b1; is_imm = 1'b1; single_src = 1'b1;
      end
      6'd40: begin                                         // BEZ
        branch_type = 2'b01; is_imm = 1'b1; single_src = 1'b1;
      end
      6'd41: begin                                         // BNE
        branch_type = 2'b10; is_imm = 1'b1;
      end
      6'd42: begin                                         // JMP
        branch_type = 2'b11; is_imm = 1'b1; single_src = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_regfile.sv
// id_regfile: architectural register file for the ID stage.
// Ports:
//   clk_i, rst_ni              clock; synchronous active-low clear of every entry
//   rd_addr1_i / rd_data1_o    async read port 1
//   rd_addr2_i / rd_data2_o    async read port 2
//   wr_en_i, wr_addr_i, wr_data_i  write port, updated on the rising edge
// Register 0 and indices >= NUM_REGS read as 0 and ignore writes. With
// BYPASS=1 a same-cycle write to the register being read is forwarded.
module id_regfile #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int BYPASS   = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [4:0]        rd_addr1_i,
  output logic [DATA_W-1:0] rd_data1_o,
  input  logic [4:0]        rd_addr2_i,
  output logic [DATA_W-1:0] rd_data2_o,
  input  logic              wr_en_i,
  input  logic [4:0]        wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i
);

  localparam int AW = $clog2(NUM_REGS);

  logic [DATA_W-1:0] rf_q [NUM_REGS];

  function automatic logic live_reg(input logic [4:0] a);
    return (a != 5'd0) && ({27'd0, a} < 32'(NUM_REGS));
  endfunction

  logic wr_ok;
  logic rd1_ok, rd2_ok;
  logic byp1, byp2;

  assign wr_ok  = wr_en_i && live_reg(wr_addr_i);
  assign rd1_ok = live_reg(rd_addr1_i);
  assign rd2_ok = live_reg(rd_addr2_i);

  // wr_ok already excludes register 0 and out-of-range targets.
  assign byp1 = (BYPASS != 0) && wr_ok && (wr_addr_i == rd_addr1_i);
  assign byp2 = (BYPASS != 0) && wr_ok && (wr_addr_i == rd_addr2_i);

  assign rd_data1_o = byp1   ? wr_data_i :
                      rd1_ok ? rf_q[rd_addr1_i[AW-1:0]] : '0;
  assign rd_data2_o = byp2   ? wr_data_i :
                      rd2_ok ? rf_q[rd_addr2_i[AW-1:0]] : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wr_ok) begin
      rf_q[wr_addr_i[AW-1:0]] <= wr_data_i;
    end
  end

endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: instruction decode with integrated ID/EXE pipeline register.
// Ports:
//   clk_i, rst_ni           clock; synchronous active-low reset
//   instr_i, instr_valid_i  instruction from IF/ID and its valid flag
//   pc_in_i                 PC of instr_i
//   hazard_detected_i       insert a bubble
//   flush_i                 kill the registered contents
//   exe_stall_i             EXE cannot accept; hold the registered outputs
//   wb_we_i, wb_dest_i, wb_data_i  register file write-back port
//   src1_o, src2_o          combinational source indices (hazard unit)
//   two_src_o               combinational: instruction reads src2
//   stall_fetch_o           combinational: hazard_detected_i | exe_stall_i
//   valid_out_o .. single_src_o  registered ID/EXE outputs
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int BYPASS   = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [31:0]       instr_i,
  input  logic              instr_valid_i,
  input  logic [31:0]       pc_in_i,
  input  logic              hazard_detected_i,
  input  logic              flush_i,
  input  logic              exe_stall_i,
  input  logic              wb_we_i,
  input  logic [4:0]        wb_dest_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic [4:0]        src1_o,
  output logic [4:0]        src2_o,
  output logic              two_src_o,
  output logic              stall_fetch_o,
  output logic              valid_out_o,
  output logic [31:0]       pc_out_o,
  output logic [DATA_W-1:0] val1_o,
  output logic [DATA_W-1:0] val2_o,
  output logic [DATA_W-1:0] reg2_o,
  output logic [4:0]        dest_o,
  output logic [3:0]        exe_cmd_o,
  output logic [1:0]        br_type_o,
  output logic              mem_r_en_o,
  output logic              mem_w_en_o,
  output logic              wb_en_o,
  output logic              single_src_o
);

  // Field extraction
  logic [4:0]              rs1, rs2, rd_fld;
  logic signed [IMM_W-1:0] imm_s;
  logic [DATA_W-1:0]       imm_ext;

  assign rs1     = instr_i[RS1_HI:RS1_LO];
  assign rs2     = instr_i[RS2_HI:RS2_LO];
  assign rd_fld  = instr_i[RD_HI:RD_LO];
  assign imm_s   = instr_i[IMM_W-1:0];
  assign imm_ext = DATA_W'(imm_s);

  // Control decode
  logic [3:0] cu_exec_cmd;
  logic       cu_mem_r_en, cu_mem_w_en, cu_wb_en, cu_is_imm, cu_single_src;
  logic [1:0] cu_branch_type;
  id_ctrl_t   ctrl_dec;

  Control_unit u_ctrl (
    .opcode      (instr_i[OPC_HI:OPC_LO]),
    .exec_cmd    (cu_exec_cmd),
    .mem_r_en    (cu_mem_r_en),
    .mem_w_en    (cu_mem_w_en),
    .wb_en       (cu_wb_en),
    .is_imm      (cu_is_imm),
    .branch_type (cu_branch_type),
    .single_src  (cu_single_src)
  );

  assign ctrl_dec = '{exe_cmd:    cu_exec_cmd,
                      mem_r_en:   cu_mem_r_en,
                      mem_w_en:   cu_mem_w_en,
                      wb_en:      cu_wb_en,
                      is_imm:     cu_is_imm,
                      br_type:    cu_branch_type,
                      single_src: cu_single_src};

  // Register file
  logic [DATA_W-1:0] rf_rd1, rf_rd2;

  id_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .BYPASS   (BYPASS)
  ) u_rf (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .rd_addr1_i (rs1),
    .rd_data1_o (rf_rd1),
    .rd_addr2_i (rs2),
    .rd_data2_o (rf_rd2),
    .wr_en_i    (wb_we_i),
    .wr_addr_i  (wb_dest_i),
    .wr_data_i  (wb_data_i)
  );

  // Hazard-unit side outputs
  assign src1_o        = rs1;
  assign src2_o        = rs2;
  assign two_src_o     = !ctrl_dec.single_src || ctrl_dec.mem_w_en;
  assign stall_fetch_o = hazard_detected_i || exe_stall_i;

  // ID/EXE register
  logic              valid_q, valid_d;
  logic [31:0]       pc_q, pc_d;
  logic [DATA_W-1:0] val1_q, val1_d;
  logic [DATA_W-1:0] val2_q, val2_d;
  logic [DATA_W-1:0] reg2_q, reg2_d;
  logic [4:0]        dest_q, dest_d;
  exe_ctrl_t         ctrl_q, ctrl_d;

  logic bubble;

  // flush beats exe_stall; hazard/invalid only bubble when EXE is accepting.
  assign bubble = flush_i || (!exe_stall_i && (hazard_detected_i || !instr_valid_i));

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    val1_d  = val1_q;
    val2_d  = val2_q;
    reg2_d  = reg2_q;
    dest_d  = dest_q;
    ctrl_d  = ctrl_q;
    if (bubble) begin
      valid_d = 1'b0;
      pc_d    = '0;
      val1_d  = '0;
      val2_d  = '0;
      reg2_d  = '0;
      dest_d  = '0;
      ctrl_d  = '0;
    end else if (!exe_stall_i) begin
      valid_d = 1'b1;
      pc_d    = pc_in_i;
      val1_d  = rf_rd1;
      val2_d  = ctrl_dec.is_imm ? imm_ext : rf_rd2;
      reg2_d  = rf_rd2;
      dest_d  = dest_sel(ctrl_dec.is_imm, rs2, rd_fld);
      ctrl_d  = '{exe_cmd:    ctrl_dec.exe_cmd,
                  br_type:    ctrl_dec.br_type,
                  mem_r_en:   ctrl_dec.mem_r_en,
                  mem_w_en:   ctrl_dec.mem_w_en,
                  wb_en:      ctrl_dec.wb_en,
                  single_src: ctrl_dec.single_src};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      val1_q  <= '0;
      val2_q  <= '0;
      reg2_q  <= '0;
      dest_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      val1_q  <= val1_d;
      val2_q  <= val2_d;
      reg2_q  <= reg2_d;
      dest_q  <= dest_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign valid_out_o  = valid_q;
  assign pc_out_o     = pc_q;
  assign val1_o       = val1_q;
  assign val2_o       = val2_q;
  assign reg2_o       = reg2_q;
  assign dest_o       = dest_q;
  assign exe_cmd_o    = ctrl_q.exe_cmd;
  assign br_type_o    = ctrl_q.br_type;
  assign mem_r_en_o   = ctrl_q.mem_r_en;
  assign mem_w_en_o   = ctrl_q.mem_w_en;
  assign wb_en_o      = ctrl_q.wb_en;
  assign single_src_o = ctrl_q.single_src;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe. Two instances share one stimulus stream:
//   A: DATA_W=32, NUM_REGS=32, BYPASS=1
//   B: DATA_W=64, NUM_REGS=16, BYPASS=0
module tb_id_stage_pipe;

  localparam int NR_A = 32;
  localparam int NR_B = 16;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic        hazard, flush, exe_stall, wb_we;
  logic [4:0]  wb_dest;
  logic [63:0] wb_data;

  logic [4:0]  a_src1, a_src2, a_dest, b_src1, b_src2, b_dest;
  logic        a_two_src, a_stall_fetch, a_valid, a_mr, a_mw, a_wb, a_ss;
  logic        b_two_src, b_stall_fetch, b_valid, b_mr, b_mw, b_wb, b_ss;
  logic [31:0] a_pc, b_pc;
  logic [31:0] a_val1, a_val2, a_reg2;
  logic [63:0] b_val1, b_val2, b_reg2;
  logic [3:0]  a_cmd, b_cmd;
  logic [1:0]  a_br, b_br;

  id_stage_pipe #(.DATA_W(32), .NUM_REGS(NR_A), .BYPASS(1)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .instr_i(instr), .instr_valid_i(instr_valid),
    .pc_in_i(pc), .hazard_detected_i(hazard), .flush_i(flush), .exe_stall_i(exe_stall),
    .wb_we_i(wb_we), .wb_dest_i(wb_dest), .wb_data_i(wb_data[31:0]),
    .src1_o(a_src1), .src2_o(a_src2), .two_src_o(a_two_src), .stall_fetch_o(a_stall_fetch),
    .valid_out_o(a_valid), .pc_out_o(a_pc), .val1_o(a_val1), .val2_o(a_val2),
    .reg2_o(a_reg2), .dest_o(a_dest), .exe_cmd_o(a_cmd), .br_type_o(a_br),
    .mem_r_en_o(a_mr), .mem_w_en_o(a_mw), .wb_en_o(a_wb), .single_src_o(a_ss)
  );

  id_stage_pipe #(.DATA_W(64), .NUM_REGS(NR_B), .BYPASS(0)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .instr_i(instr), .instr_valid_i(instr_valid),
    .pc_in_i(pc), .hazard_detected_i(hazard), .flush_i(flush), .exe_stall_i(exe_stall),
    .wb_we_i(wb_we), .wb_dest_i(wb_dest), .wb_data_i(wb_data),
    .src1_o(b_src1), .src2_o(b_src2), .two_src_o(b_two_src), .stall_fetch_o(b_stall_fetch),
    .valid_out_o(b_valid), .pc_out_o(b_pc), .val1_o(b_val1), .val2_o(b_val2),
    .reg2_o(b_reg2), .dest_o(b_dest), .exe_cmd_o(b_cmd), .br_type_o(b_br),
    .mem_r_en_o(b_mr), .mem_w_en_o(b_mw), .wb_en_o(b_wb), .single_src_o(b_ss)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [63:0] v, pc, v1, v2, r2, dest, cmd, br, mr, mw, wb, ss;
  } pipe_t;

  pipe_t       exp_p [2];
  logic [63:0] mrf [2][32];

  function automatic int cfg_nr(input int c);
    return (c == 0) ? NR_A : NR_B;
  endfunction

  function automatic logic [63:0] cfg_mask(input int c);
    return (c == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  // Opcode table: {exe_cmd[3:0], mr, mw, wb, is_imm, br[1:0], single_src}
  function automatic logic [10:0] ctl_of(input logic [5:0] op);
    case (op)
      6'd1:  return {4'd0,  7'b0010000};
      6'd3:  return {4'd2,  7'b0010000};
      6'd5:  return {4'd4,  7'b0010000};
      6'd6:  return {4'd5,  7'b0010000};
      6'd7:  return {4'd6,  7'b0010000};
      6'd8:  return {4'd7,  7'b0010000};
      6'd9:  return {4'd8,  7'b0010000};
      6'd10: return {4'd8,  7'b0010000};
      6'd11: return {4'd9,  7'b0010000};
      6'd12: return {4'd10, 7'b0010000};
      6'd32: return {4'd0,  7'b0011001};
      6'd33: return {4'd2,  7'b0011001};
      6'd36: return {4'd0,  7'b1011001};
      6'd37: return {4'd0,  7'b0101001};
      6'd40: return {4'd0,  7'b0001011};
      6'd41: return {4'd0,  7'b0001100};
      6'd42: return {4'd0,  7'b0001111};
      default: return 11'd0;
    endcase
  endfunction

  function automatic logic [63:0] rd_model(input int c, input logic [4:0] idx);
    logic wb_live;
    wb_live = wb_we && (wb_dest != 5'd0) && (int'(wb_dest) < cfg_nr(c));
    if (c == 0 && wb_live && wb_dest == idx) return wb_data & cfg_mask(c);
    if (idx == 5'd0 || int'(idx) >= cfg_nr(c)) return 64'd0;
    return mrf[c][idx];
  endfunction

  task automatic model_edge();
    logic [10:0] ct;
    logic [63:0] imm_x;
    pipe_t       n;
    ct    = ctl_of(instr[31:26]);
    imm_x = instr[15] ? {48'hFFFF_FFFF_FFFF, instr[15:0]} : {48'd0, instr[15:0]};
    for (int c = 0; c < 2; c++) begin
      n = exp_p[c];
      if (!rst_n) begin
        n = '0;
        for (int r = 0; r < 32; r++) mrf[c][r] = 64'd0;
      end else begin
        if (flush) n = '0;
        else if (exe_stall) n = exp_p[c];
        else if (hazard || !instr_valid) n = '0;
        else begin
          n.v    = 64'd1;
          n.pc   = {32'd0, pc};
          n.v1   = rd_model(c, instr[25:21]);
          n.r2   = rd_model(c, instr[20:16]);
          n.v2   = ct[3] ? (imm_x & cfg_mask(c)) : n.r2;
          n.dest = {59'd0, ct[3] ? instr[20:16] : instr[15:11]};
          n.cmd  = {60'd0, ct[10:7]};
          n.mr   = {63'd0, ct[6]};
          n.mw   = {63'd0, ct[5]};
          n.wb   = {63'd0, ct[4]};
          n.br   = {62'd0, ct[2:1]};
          n.ss   = {63'd0, ct[0]};
        end
        if (wb_we && wb_dest != 5'd0 && int'(wb_dest) < cfg_nr(c))
          mrf[c][wb_dest] = wb_data & cfg_mask(c);
      end
      exp_p[c] = n;
    end
  endtask

  task automatic cmp_regs();
    pipe_t g;
    string p;
    for (int c = 0; c < 2; c++) begin
      if (c == 0) begin
        p = "A.";
        g = '{v: 64'(a_valid), pc: 64'(a_pc), v1: 64'(a_val1), v2: 64'(a_val2),
              r2: 64'(a_reg2), dest: 64'(a_dest), cmd: 64'(a_cmd), br: 64'(a_br),
              mr: 64'(a_mr), mw: 64'(a_mw), wb: 64'(a_wb), ss: 64'(a_ss)};
      end else begin
        p = "B.";
        g = '{v: 64'(b_valid), pc: 64'(b_pc), v1: b_val1, v2: b_val2,
              r2: b_reg2, dest: 64'(b_dest), cmd: 64'(b_cmd), br: 64'(b_br),
              mr: 64'(b_mr), mw: 64'(b_mw), wb: 64'(b_wb), ss: 64'(b_ss)};
      end
      check_eq({p, "valid"}, g.v,    exp_p[c].v);
      check_eq({p, "pc"},    g.pc,   exp_p[c].pc);
      check_eq({p, "val1"},  g.v1,   exp_p[c].v1);
      check_eq({p, "val2"},  g.v2,   exp_p[c].v2);
      check_eq({p, "reg2"},  g.r2,   exp_p[c].r2);
      check_eq({p, "dest"},  g.dest, exp_p[c].dest);
      check_eq({p, "cmd"},   g.cmd,  exp_p[c].cmd);
      check_eq({p, "br"},    g.br,   exp_p[c].br);
      check_eq({p, "mr"},    g.mr,   exp_p[c].mr);
      check_eq({p, "mw"},    g.mw,   exp_p[c].mw);
      check_eq({p, "wb"},    g.wb,   exp_p[c].wb);
      check_eq({p, "ss"},    g.ss,   exp_p[c].ss);
    end
  endtask

  // Inputs are already driven; check combinational outputs, advance one edge,
  // then compare the registered outputs.
  task automatic cycle();
    logic [10:0] ct;
    #1;
    ct = ctl_of(instr[31:26]);
    check_eq("A.src1", 64'(a_src1), 64'(instr[25:21]));
    check_eq("B.src2", 64'(b_src2), 64'(instr[20:16]));
    check_eq("A.src2", 64'(a_src2), 64'(instr[20:16]));
    check_eq("B.src1", 64'(b_src1), 64'(instr[25:21]));
    check_eq("A.two_src", 64'(a_two_src), 64'(!ct[0] || ct[5]));
    check_eq("B.two_src", 64'(b_two_src), 64'(!ct[0] || ct[5]));
    check_eq("A.stall_fetch", 64'(a_stall_fetch), 64'(hazard || exe_stall));
    check_eq("B.stall_fetch", 64'(b_stall_fetch), 64'(hazard || exe_stall));
    model_edge();
    @(posedge clk);
    #1;
    cmp_regs();
  endtask

  task automatic set_idle();
    rst_n       = 1'b1;
    instr_valid = 1'b0;
    hazard      = 1'b0;
    flush       = 1'b0;
    exe_stall   = 1'b0;
    wb_we       = 1'b0;
    wb_dest     = 5'd0;
    wb_data     = 64'd0;
  endtask

  function automatic logic [31:0] mk_r(input logic [5:0] op, input logic [4:0] s1,
                                       input logic [4:0] s2, input logic [4:0] rd);
    return {op, s1, s2, rd, 11'd0};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] s1,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, s1, rt, imm};
  endfunction

  logic [5:0] ops [17] = '{6'd0, 6'd1, 6'd3, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10,
                           6'd11, 6'd12, 6'd32, 6'd33, 6'd36, 6'd37, 6'd40, 6'd41};

  initial begin
    for (int c = 0; c < 2; c++) begin
      exp_p[c] = '0;
      for (int r = 0; r < 32; r++) mrf[c][r] = 64'd0;
    end
    instr = 32'd0;
    pc    = 32'd0;

    // reset held 2 cycles with a valid instruction
    set_idle();
    rst_n = 1'b0; instr = mk_r(6'd3, 5'd1, 5'd2, 5'd3); instr_valid = 1'b1; pc = 32'h40;
    cycle();
    cycle();
    check_eq("rst.valid", 64'(a_valid), 64'd0);
    check_eq("rst.cmd",   64'(b_cmd),   64'd0);

    // reset clears the register file
    set_idle(); wb_we = 1'b1; wb_dest = 5'd5; wb_data = 64'h1234;
    cycle();
    set_idle(); rst_n = 1'b0;
    cycle();
    set_idle(); instr = mk_r(6'd1, 5'd5, 5'd0, 5'd9); instr_valid = 1'b1;
    cycle();
    check_eq("rst.rf5.A", 64'(a_val1), 64'd0);
    check_eq("rst.rf5.B", b_val1, 64'd0);

    // same-cycle write and read of r3
    set_idle(); instr = mk_r(6'd1, 5'd3, 5'd0, 5'd4); instr_valid = 1'b1;
    wb_we = 1'b1; wb_dest = 5'd3; wb_data = 64'hDEAD_BEEF;
    cycle();
    check_eq("byp.A", 64'(a_val1), 64'hDEAD_BEEF);
    check_eq("byp.B", b_val1, 64'd0);
    wb_we = 1'b0;
    cycle();
    check_eq("byp.B.next", b_val1, 64'hDEAD_BEEF);

    // immediate sign extension and dest select
    set_idle(); instr = mk_i(6'd32, 5'd3, 5'd7, 16'hFFF0); instr_valid = 1'b1;
    cycle();
    check_eq("imm.A.val2", 64'(a_val2), 64'hFFFF_FFF0);
    check_eq("imm.B.val2", b_val2, 64'hFFFF_FFFF_FFFF_FFF0);
    check_eq("imm.A.dest", 64'(a_dest), 64'd7);

    // writes to r0 and r20 (out of range for B)
    set_idle(); wb_we = 1'b1; wb_dest = 5'd0; wb_data = 64'd55;
    cycle();
    wb_dest = 5'd20; wb_data = 64'd66;
    cycle();
    set_idle(); instr = mk_r(6'd1, 5'd0, 5'd20, 5'd1); instr_valid = 1'b1;
    cycle();
    check_eq("r0.A", 64'(a_val1), 64'd0);
    check_eq("r20.A", 64'(a_reg2), 64'd66);
    check_eq("r0.B", b_val1, 64'd0);
    check_eq("r20.B", b_reg2, 64'd0);

    // exe_stall holds for 3 cycles while instr changes
    set_idle(); instr = mk_r(6'd3, 5'd3, 5'd20, 5'd6); instr_valid = 1'b1; pc = 32'h100;
    cycle();
    for (int i = 0; i < 3; i++) begin
      exe_stall = 1'b1; hazard = (i == 1);
      instr = $urandom; pc = $urandom;
      cycle();
      check_eq("stall.pc", 64'(a_pc), 64'h100);
      check_eq("stall.cmd", 64'(b_cmd), 64'd2);
    end

    // hazard without stall
    set_idle(); instr = mk_r(6'd1, 5'd1, 5'd1, 5'd1); instr_valid = 1'b1;
    cycle();
    hazard = 1'b1;
    cycle();
    check_eq("haz.valid", 64'(a_valid), 64'd0);
    check_eq("haz.wb", 64'(a_wb), 64'd0);

    // flush with stall
    set_idle(); instr = mk_r(6'd5, 5'd2, 5'd3, 5'd4); instr_valid = 1'b1;
    cycle();
    exe_stall = 1'b1; flush = 1'b1;
    cycle();
    check_eq("flush.valid", 64'(b_valid), 64'd0);

    // reset mid-stall
    set_idle(); instr = mk_r(6'd3, 5'd3, 5'd3, 5'd8); instr_valid = 1'b1;
    cycle();
    exe_stall = 1'b1; rst_n = 1'b0;
    cycle();
    check_eq("mrst.valid", 64'(a_valid), 64'd0);
    check_eq("mrst.cmd", 64'(a_cmd), 64'd0);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      logic [5:0] op;
      logic [4:0] r1;
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 16)];
      r1 = 5'($urandom_range(0, 31));
      instr       = {op, r1, 5'($urandom_range(0, 31)), 5'($urandom), 16'($urandom)};
      rst_n       = ($urandom_range(0, 49) != 0);
      instr_valid = ($urandom_range(0, 9) != 0);
      pc          = $urandom;
      hazard      = ($urandom_range(0, 6) == 0);
      flush       = ($urandom_range(0, 9) == 0);
      exe_stall   = ($urandom_range(0, 4) == 0);
      wb_we       = ($urandom_range(0, 1) == 1);
      wb_dest     = ($urandom_range(0, 9) < 3) ? r1 : 5'($urandom_range(0, 31));
      wb_data     = {$urandom, $urandom};
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
